// File: rtl/sr_cmd_debouncer.sv
// ============================================================================
// Module   : sr_cmd_debouncer
// Purpose  : Push-button front end for sr_latch. Synchronises and debounces the
//            raw set/reset buttons and issues clean one-cycle s/r pulses that
//            are never asserted together, with a forced idle gap after each.
//            Tracks the expected latch Q and flags simultaneous requests.
// Options  : SR_CMD_CONFLICT_CNT_EN adds an 8-bit saturating conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cmd_debouncer #(
  parameter int DB_CYCLES = 4,
  parameter int MIN_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_s,
  input  logic       btn_r,
  output logic       s,
  output logic       r,
  output logic       conflict,
  output logic       state_q
`ifdef SR_CMD_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam int GW = $clog2(MIN_GAP) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE_S = 2'd1;
  localparam logic [1:0] PULSE_R = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  // Channel index 0 = set button, 1 = reset button.
  logic [1:0]    btn_w;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    fill_q;
  logic [1:0]    db_q, db_prev_q, arm_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    req_w;

  logic [1:0]    fsm_q, fsm_d;
  logic [GW-1:0] gap_q;
  logic          pend_s_q, pend_r_q;
  logic          want_s_w, want_r_w;
  logic          s_q, s_d, r_q, r_d, conflict_q, conflict_d;
  logic          latch_q;

  assign btn_w = {btn_r, btn_s};

  // Two-flop synchronisers; fill_q marks when sync2 reflects real button levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= btn_w;
      sync2_q <= sync1_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end

  // Debounce: db flips once the synced level has differed for DB_CYCLES samples.
  // A channel is armed only after its button has been seen released, so a
  // button still held across a reset cannot fire a fresh request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q      <= 2'b00;
      db_prev_q <= 2'b00;
      arm_q     <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (cnt_q[i] == CW'(DB_CYCLES)) begin
          db_q[i]  <= ~db_q[i];
          cnt_q[i] <= '0;
        end else if (sync2_q[i] != db_q[i]) begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end else begin
          cnt_q[i] <= '0;
        end
        if (fill_q == 2'd2 && !sync2_q[i] && !db_q[i]) arm_q[i] <= 1'b1;
      end
    end
  end

  assign req_w    = db_q & ~db_prev_q & arm_q;
  assign want_s_w = req_w[0] | pend_s_q;
  assign want_r_w = req_w[1] | pend_r_q;

  // FSM state register plus gap counter, pending bits and expected latch state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      gap_q    <= '0;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      gap_q <= (fsm_q == GAP) ? gap_q + GW'(1) : '0;
      if (fsm_q == IDLE) begin
        pend_s_q <= 1'b0;
        pend_r_q <= 1'b0;
      end else begin
        pend_s_q <= pend_s_q | req_w[0];
        pend_r_q <= pend_r_q | req_w[1];
      end
      if (fsm_q == PULSE_S) latch_q <= 1'b1;
      else if (fsm_q == PULSE_R) latch_q <= 1'b0;
    end
  end

  // Next-state logic: a lone request is served, a simultaneous pair is dropped.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (want_s_w && !want_r_w) fsm_d = PULSE_S;
        else if (want_r_w && !want_s_w) fsm_d = PULSE_R;
      end
      PULSE_S, PULSE_R: fsm_d = GAP;
      GAP: if (gap_q == GW'(MIN_GAP - 1)) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Output decode, registered below so s/r/conflict come straight from flops.
  always_comb begin
    s_d        = (fsm_d == PULSE_S);
    r_d        = (fsm_d == PULSE_R);
    conflict_d = (fsm_q == IDLE) && want_s_w && want_r_w;
  end

  // Output registers; async reset drops an in-flight pulse immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign state_q  = latch_q;

`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] ccnt_q;

  // Saturating count of dropped set/reset pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ccnt_q <= 8'd0;
    else if (conflict_q && ccnt_q != 8'hFF) ccnt_q <= ccnt_q + 8'd1;
  end

  assign conflict_cnt = ccnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_debouncer.sv
// ============================================================================
// Module   : tb_sr_cmd_debouncer
// Purpose  : Directed self-checking bench for sr_cmd_debouncer (defaults
//            DB_CYCLES=4, MIN_GAP=2). Cycle k is the interval after rising
//            edge k; outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_cmd_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_s = 1'b0;
  logic btn_r = 1'b0;
  logic s, r, conflict, state_q;
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_cmd_debouncer #(.DB_CYCLES(4), .MIN_GAP(2)) dut (
    .clk(clk),
    .rst(rst),
    .btn_s(btn_s),
    .btn_r(btn_r),
    .s(s),
    .r(r),
    .conflict(conflict),
    .state_q(state_q)
`ifdef SR_CMD_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  // Reset, then leave a few idle cycles so the synchronisers settle.
  // Returns on a falling edge; the next rising edge is edge 0.
  task automatic do_reset();
    rst = 1'b1;
    btn_s = 1'b0;
    btn_r = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    #3;
    checks++;
    obs = {s, r, conflict, state_q};
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_asserted: got s,r,c,q=%b want 0000", obs);
    end
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      obs = {s, r, conflict, state_q};
      if (obs !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got s,r,c,q=%b want 0000", k, obs);
      end
    end
  endtask

  task automatic test_single_set();
    logic [3:0] obs, exp;
    do_reset();
    btn_s = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      exp = {(k == 7), 1'b0, 1'b0, (k >= 8)};
      obs = {s, r, conflict, state_q};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single_set cycle %0d: got s,r,c,q=%b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses;
    // Three cycles high: must be rejected.
    do_reset();
    pulses = 0;
    btn_s = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (k == 2) begin @(negedge clk); btn_s = 1'b0; end
      else @(negedge clk);
      if (s === 1'b1) pulses++;
      checks++;
      if (state_q !== 1'b0 || r !== 1'b0) begin
        failures++;
        $display("FAIL glitch3_state cycle %0d: got q=%b r=%b want 0 0", k, state_q, r);
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL glitch3_pulses: got %0d want 0", pulses);
    end
    // Four cycles high: exactly one pulse, in cycle 7.
    do_reset();
    pulses = 0;
    btn_s = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) btn_s = 1'b0;
      if (s === 1'b1) begin
        pulses++;
        checks++;
        if (k != 7) begin
          failures++;
          $display("FAIL glitch4_when: got pulse in cycle %0d want 7", k);
        end
      end
    end
    checks++;
    if (pulses != 1 || state_q !== 1'b1) begin
      failures++;
      $display("FAIL glitch4_pulses: got %0d pulses q=%b want 1 pulse q=1", pulses, state_q);
    end
  endtask

  // Runs right after test_single_set, so state_q starts at 1.
  task automatic test_conflict();
    logic [3:0] obs, exp;
    btn_s = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (state_q !== 1'b1) begin
      failures++;
      $display("FAIL conflict_pre: got q=%b want 1", state_q);
    end
    btn_s = 1'b1;
    btn_r = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      exp = {1'b0, 1'b0, (k == 7), 1'b1};
      obs = {s, r, conflict, state_q};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL conflict cycle %0d: got s,r,c,q=%b want %b", k, obs, exp);
      end
    end
`ifdef SR_CMD_CONFLICT_CNT_EN
    checks++;
    if (conflict_cnt !== 8'd1) begin
      failures++;
      $display("FAIL conflict_cnt: got %0d want 1", conflict_cnt);
    end
`endif
    btn_s = 1'b0;
    btn_r = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    do_reset();
    btn_s = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) btn_r = 1'b1;
      exp = {(k == 7), (k == 11), 1'b0, (k >= 8 && k <= 11)};
      obs = {s, r, conflict, state_q};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got s,r,c,q=%b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [3:0] obs;
    do_reset();
    btn_s = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (s !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pulse_seen: got s=%b want 1", s);
    end
    #2 rst = 1'b1;
    #1;
    obs = {s, r, conflict, state_q};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_drop: got s,r,c,q=%b want 0000", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {s, r, conflict, state_q};
      checks++;
      if (obs !== 4'b0000) begin
        failures++;
        $display("FAIL midreset_after cycle %0d: got s,r,c,q=%b want 0000", k, obs);
      end
    end
    btn_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_conflict();
    test_glitch();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
